// File: rtl/exhaustive_vector_gen.sv
// Exhaustive stimulus sequencer: walks every WIDTH-bit vector, waits a settle time, then hands it off via valid/ready.
// Optional macro VECGEN_GRAY_EN drives vec_out in Gray code instead of plain binary.
module exhaustive_vector_gen #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int LOOP        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   vec_count
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_ACK, DONE} state_t;

  localparam int SW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin, bin_nxt;
  logic [SW-1:0]    settle, settle_nxt;
  logic             valid_nxt;
  logic [WIDTH:0]   count_nxt;

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
`ifdef VECGEN_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  always_comb begin
    state_nxt  = state;
    bin_nxt    = bin;
    settle_nxt = settle;
    valid_nxt  = vec_valid;
    count_nxt  = vec_count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = HOLD;
          bin_nxt    = '0;
          settle_nxt = '0;
          count_nxt  = '0;
          valid_nxt  = 1'b0;
        end
      end
      HOLD: begin
        // Settle time only advances on unpaused cycles.
        if (!pause) begin
          if (settle == SETTLE_LAST) begin
            state_nxt = WAIT_ACK;
            valid_nxt = 1'b1;
          end else begin
            settle_nxt = settle + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (vec_ready) begin
          valid_nxt = 1'b0;
          count_nxt = vec_count + 1'b1;
          if ((&bin) && (LOOP == 0)) begin
            state_nxt = DONE;
          end else begin
            bin_nxt    = bin + 1'b1;
            settle_nxt = '0;
            state_nxt  = HOLD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is registered from the next-state values so nothing glitches into the DUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      settle    <= '0;
      vec_valid <= 1'b0;
      vec_count <= '0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin       <= bin_nxt;
      settle    <= settle_nxt;
      vec_valid <= valid_nxt;
      vec_count <= count_nxt;
      vec_out   <= encode(bin_nxt);
      busy      <= (state_nxt == HOLD) || (state_nxt == WAIT_ACK);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_exhaustive_vector_gen.sv
// Directed bench for exhaustive_vector_gen: one-shot and looping instances, scoreboard of expected vectors.
module tb_exhaustive_vector_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, pause0, ready0;
  logic [2:0] vec0;
  logic       valid0, busy0, done0;
  logic [3:0] count0;
  logic       start1, pause1, ready1;
  logic [2:0] vec1;
  logic       valid1, busy1, done1;
  logic [3:0] count1;

  int errors = 0;
  int checks = 0;
  logic [2:0] sb0[$];
  logic [2:0] sb1[$];

  always #5 clk = ~clk;

  exhaustive_vector_gen #(.WIDTH(3), .HOLD_CYCLES(5), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pause(pause0),
    .vec_out(vec0), .vec_valid(valid0), .vec_ready(ready0),
    .busy(busy0), .done(done0), .vec_count(count0)
  );

  exhaustive_vector_gen #(.WIDTH(3), .HOLD_CYCLES(5), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1),
    .vec_out(vec1), .vec_valid(valid1), .vec_ready(ready1),
    .busy(busy1), .done(done1), .vec_count(count1)
  );

  function automatic logic [2:0] exp_vec(input int b);
    logic [2:0] x;
    x = b[2:0];
`ifdef VECGEN_GRAY_EN
    return x ^ (x >> 1);
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for vec_valid on dut0, continuing a latency count already in progress.
  task automatic wait_valid0(inout int lat);
    while (valid0 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [2:0] e;
    rst_n = 1'b1; start0 = 0; pause0 = 0; ready0 = 1;
    start1 = 0; pause1 = 0; ready1 = 1;
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_vec", vec0, 0);
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_count", count0, 0);
    rst_n = 1'b1;
    tick();

    // One-shot sweep with start-in-HOLD, pause, and backpressure events.
    for (int v = 0; v < 8; v++) sb0.push_back(exp_vec(v));
    start0 = 1; tick(); start0 = 0;
    check("start_busy", busy0, 1);
    for (int v = 0; v < 8; v++) begin
      lat = 0;
      if (v == 1) begin start0 = 1; tick(); lat++; start0 = 0; end
      if (v == 2) begin
        tick(); lat++;
        pause0 = 1;
        repeat (4) begin tick(); lat++; end
        pause0 = 0;
      end
      if (v == 3) ready0 = 0;
      wait_valid0(lat);
      e = sb0.pop_front();
      check($sformatf("vec_%0d", v), vec0, e);
      check($sformatf("lat_%0d", v), lat, (v == 2) ? 9 : 5);
      check($sformatf("cnt_%0d", v), count0, v);
      check($sformatf("busy_%0d", v), busy0, 1);
      if (v == 3) begin
        for (int k = 0; k < 10; k++) begin
          tick();
          check($sformatf("bp_vec_%0d", k), vec0, e);
          check($sformatf("bp_valid_%0d", k), valid0, 1);
        end
        ready0 = 1;
        tick();
        check("bp_advance", vec0, exp_vec(4));
        check("bp_valid_drop", valid0, 0);
      end else begin
        tick();
      end
    end
    check("done_flag", done0, 1);
    check("done_busy", busy0, 0);
    check("done_valid", valid0, 0);
    check("done_count", count0, 8);
    check("done_vec", vec0, exp_vec(7));
    repeat (3) tick();
    check("done_hold_vec", vec0, exp_vec(7));
    check("done_hold_flag", done0, 1);
    check("done_hold_count", count0, 8);

    // Restart from DONE, then reset while waiting for ack on vector 5.
    start0 = 1; tick(); start0 = 0;
    check("restart_vec", vec0, exp_vec(0));
    check("restart_count", count0, 0);
    check("restart_done", done0, 0);
    for (int v = 0; v < 6; v++) sb0.push_back(exp_vec(v));
    for (int v = 0; v < 6; v++) begin
      lat = 0;
      if (v == 5) ready0 = 0;
      wait_valid0(lat);
      check($sformatf("r_vec_%0d", v), vec0, sb0.pop_front());
      check($sformatf("r_lat_%0d", v), lat, 5);
      if (v < 5) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_vec", vec0, 0);
    check("arst_valid", valid0, 0);
    check("arst_busy", busy0, 0);
    check("arst_count", count0, 0);
    check("arst_done", done0, 0);
    tick();
    rst_n = 1'b1;
    ready0 = 1;
    tick();
    check("post_rst_idle", busy0, 0);
    start0 = 1; tick(); start0 = 0;
    check("post_rst_vec", vec0, exp_vec(0));
    check("post_rst_count", count0, 0);
    lat = 0;
    wait_valid0(lat);
    check("post_rst_lat", lat, 5);

    // Looping instance: wraps past 7 and vec_count wraps past 15.
    for (int i = 0; i < 16; i++) sb1.push_back(exp_vec(i));
    start1 = 1; tick(); start1 = 0;
    for (int i = 0; i < 16; i++) begin
      lat = 0;
      while (valid1 !== 1'b1 && lat < 64) begin tick(); lat++; end
      check($sformatf("l_vec_%0d", i), vec1, sb1.pop_front());
      check($sformatf("l_cnt_%0d", i), count1, i);
      check($sformatf("l_done_%0d", i), done1, 0);
      check($sformatf("l_lat_%0d", i), lat, 5);
      tick();
    end
    check("loop_wrap_cnt", count1, 0);
    check("loop_wrap_vec", vec1, exp_vec(0));
    check("loop_busy", busy1, 1);
    check("loop_done", done1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
